// File: rtl/fdiv_digit_synth.sv
// Digit-programmed clock synthesizer: BCD entry -> f = M*10^E -> half-period CLK_HZ/(2f).
// Build option FDIV_RANGE_CHECK_EN rejects out-of-range settings instead of clamping them.
module fdiv_digit_synth #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned NDIG    = 3,
  parameter int unsigned EXP_MAX = 5,
  parameter int unsigned CW      = 32,
  localparam int unsigned PW     = $clog2(NDIG + 1),
  localparam int unsigned DBW    = 4 * (NDIG + 1)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           digit_valid_i,
  input  logic [3:0]     digit_i,
  output logic           digit_ready_o,
  input  logic           commit_i,
  output logic           busy_o,
  output logic           err_o,
  output logic           clk_out_o,
  output logic           out_valid_o,
  output logic [CW-1:0]  half_period_o,
  output logic [DBW-1:0] disp_bcd_o,
  output logic [PW-1:0]  disp_ptr_o
);

  localparam int unsigned AW = CW + 4;
  localparam int unsigned SW = $clog2(CW + 16);

  typedef enum logic [2:0] {StIdle, StBcd, StScale, StCheck, StDiv, StPend} state_e;

  state_e          state_q;
  logic [3:0]      e_q [NDIG+1];
  logic [PW-1:0]   ptr_q;
  logic [AW-1:0]   acc_q;
  logic [AW-1:0]   div_q;
  logic [AW-1:0]   rem_q;
  logic [CW-1:0]   quo_q;
  logic [SW-1:0]   step_q;
  logic [CW-1:0]   cnt_q;
  logic            clk_q;
  logic            valid_q;
  logic [CW-1:0]   hp_q;
  logic            err_q;

  logic            digit_take;
  logic            commit_take;
  logic [3:0]      cur_dig;
  logic [3:0]      exp_eff;
  logic [AW-1:0]   acc_x10;
  logic [AW:0]     rem_sh;
  logic            rem_ge;
  logic [AW-1:0]   rem_d;
  logic [CW-1:0]   quo_d;
  logic [CW-1:0]   q_load;
  logic            gen_wrap;
  logic            boundary;
  logic            chk_reject;
  logic            chk_off;

  always_comb begin
    digit_take  = digit_valid_i && (state_q == StIdle) && (digit_i <= 4'd9);
    commit_take = commit_i && (state_q == StIdle);

    cur_dig = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (step_q == SW'(i)) cur_dig = e_q[i];
    end

    acc_x10 = (acc_q << 3) + (acc_q << 1);

    // Quotient register doubles as the dividend shifter: dividend bits leave at the MSB.
    rem_sh = {rem_q, quo_q[CW-1]};
    rem_ge = rem_sh >= {1'b0, div_q};
    rem_d  = AW'(rem_ge ? (rem_sh - {1'b0, div_q}) : rem_sh);
    quo_d  = {quo_q[CW-2:0], rem_ge};
    q_load = (quo_q == '0) ? CW'(1) : quo_q;

    gen_wrap = valid_q && (cnt_q == hp_q - CW'(1));
    boundary = gen_wrap && !clk_q;

`ifdef FDIV_RANGE_CHECK_EN
    exp_eff    = e_q[NDIG];
    chk_reject = (acc_q == '0) || (32'(e_q[NDIG]) > EXP_MAX) ||
                 ({acc_q, 1'b0} > (AW + 1)'(CLK_HZ));
    chk_off    = 1'b0;
`else
    exp_eff    = (32'(e_q[NDIG]) > EXP_MAX) ? 4'(EXP_MAX) : e_q[NDIG];
    chk_reject = 1'b0;
    chk_off    = (acc_q == '0);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      for (int unsigned i = 0; i <= NDIG; i++) e_q[i] <= '0;
      ptr_q   <= '0;
      acc_q   <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      clk_q   <= 1'b0;
      valid_q <= 1'b0;
      hp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      if (digit_take) begin
        for (int unsigned i = 0; i <= NDIG; i++) begin
          if (ptr_q == PW'(i)) e_q[i] <= digit_i;
        end
        ptr_q <= (ptr_q == PW'(NDIG)) ? '0 : ptr_q + PW'(1);
      end

      if (valid_q) begin
        if (gen_wrap) begin
          cnt_q <= '0;
          clk_q <= ~clk_q;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end

      unique case (state_q)
        StIdle: begin
          if (commit_take) begin
            err_q   <= 1'b0;
            acc_q   <= '0;
            step_q  <= SW'(NDIG - 1);
            state_q <= StBcd;
          end
        end
        StBcd: begin
          acc_q <= acc_x10 + AW'(cur_dig);
          if (step_q == '0) begin
            step_q  <= SW'(exp_eff) - SW'(1);
            state_q <= (exp_eff == 4'd0) ? StCheck : StScale;
          end else begin
            step_q <= step_q - SW'(1);
          end
        end
        StScale: begin
          acc_q <= acc_x10;
          if (step_q == '0) state_q <= StCheck;
          else step_q <= step_q - SW'(1);
        end
        StCheck: begin
          if (chk_reject) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else if (chk_off) begin
            valid_q <= 1'b0;
            clk_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            rem_q   <= '0;
            quo_q   <= CW'(CLK_HZ);
            div_q   <= {acc_q[AW-2:0], 1'b0};
            step_q  <= SW'(CW - 1);
            state_q <= StDiv;
          end
        end
        StDiv: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          if (step_q == '0) state_q <= StPend;
          else step_q <= step_q - SW'(1);
        end
        StPend: begin
          if (!valid_q) begin
            hp_q    <= q_load;
            cnt_q   <= '0;
            clk_q   <= 1'b1;
            valid_q <= 1'b1;
            state_q <= StIdle;
          end else if (boundary) begin
            // Generator already restarts cnt and raises clk_out on this cycle.
            hp_q    <= q_load;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    disp_bcd_o = '0;
    for (int unsigned i = 0; i <= NDIG; i++) disp_bcd_o[4*i +: 4] = e_q[i];
  end

  assign busy_o        = (state_q != StIdle);
  assign digit_ready_o = (state_q == StIdle);
  assign err_o         = err_q;
  assign clk_out_o     = clk_q;
  assign out_valid_o   = valid_q;
  assign half_period_o = hp_q;
  assign disp_ptr_o    = ptr_q;

endmodule

// File: tb/tb_fdiv_digit_synth.sv
// Directed bench for fdiv_digit_synth (50 MHz, NDIG = 3, CW = 32) with hand-computed expectations.
`timescale 1ns/1ps
module tb_fdiv_digit_synth;

  localparam int unsigned CW   = 32;
  localparam int unsigned NDIG = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dv = 1'b0;
  logic [3:0]    dg = 4'd0;
  logic          commit = 1'b0;
  logic          digit_ready;
  logic          busy;
  logic          err;
  logic          clk_out;
  logic          out_valid;
  logic [CW-1:0] half_period;
  logic [15:0]   disp_bcd;
  logic [1:0]    disp_ptr;

  int n_checks = 0;
  int n_fail   = 0;

  fdiv_digit_synth #(
    .CLK_HZ (50_000_000),
    .NDIG   (NDIG),
    .EXP_MAX(5),
    .CW     (CW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .digit_valid_i(dv),
    .digit_i      (dg),
    .digit_ready_o(digit_ready),
    .commit_i     (commit),
    .busy_o       (busy),
    .err_o        (err),
    .clk_out_o    (clk_out),
    .out_valid_o  (out_valid),
    .half_period_o(half_period),
    .disp_bcd_o   (disp_bcd),
    .disp_ptr_o   (disp_ptr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input logic [3:0] d);
    dv = 1'b1;
    dg = d;
    tick();
    dv = 1'b0;
    dg = 4'd0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (busy && n < 3000) begin
      n++;
      tick();
    end
    if (busy) check_eq({tag, " idle timeout"}, 64'(busy), 64'd0);
  endtask

  task automatic measure(input logic lvl, output int n);
    n = 0;
    while (clk_out === lvl && n < 5000) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int m;
    int total;

    repeat (3) tick();
    check_eq("rst busy", 64'(busy), 0);
    check_eq("rst digit_ready", 64'(digit_ready), 1);
    check_eq("rst clk_out", 64'(clk_out), 0);
    check_eq("rst out_valid", 64'(out_valid), 0);
    check_eq("rst half_period", 64'(half_period), 0);
    check_eq("rst disp_bcd", 64'(disp_bcd), 0);
    check_eq("rst err", 64'(err), 0);
    rst = 1'b0;
    tick();

    // Basic program: 100 * 10^3 Hz -> 250
    send_digit(4'd0); send_digit(4'd0); send_digit(4'd1); send_digit(4'd3);
    check_eq("basic disp_bcd", 64'(disp_bcd), 64'h3100);
    check_eq("basic ptr wrap", 64'(disp_ptr), 0);
    do_commit();
    wait_idle("basic", n);
    check_eq("basic busy cycles", 64'(n), 40);
    check_eq("basic half_period", 64'(half_period), 250);
    check_eq("basic out_valid", 64'(out_valid), 1);
    check_eq("basic first level", 64'(clk_out), 1);
    measure(1'b1, n);
    check_eq("basic high len", 64'(n), 250);
    measure(1'b0, n);
    check_eq("basic low len", 64'(n), 250);

    // Reconfigure to 1 MHz 105 cycles into the high phase
    repeat (100) tick();
    send_digit(4'd0); send_digit(4'd0); send_digit(4'd1); send_digit(4'd4);
    do_commit();
    check_eq("reconf busy", 64'(busy), 1);
    measure(1'b1, n);
    check_eq("reconf rest high", 64'(n), 145);
    check_eq("reconf old hp kept", 64'(half_period), 250);
    check_eq("reconf pending", 64'(busy), 1);
    measure(1'b0, n);
    check_eq("reconf old low", 64'(n), 250);
    check_eq("reconf new hp", 64'(half_period), 25);
    measure(1'b1, n);
    check_eq("reconf new high", 64'(n), 25);
    measure(1'b0, n);
    check_eq("reconf new low", 64'(n), 25);
    check_eq("reconf idle", 64'(busy), 0);

    // f = 0
    send_digit(4'd0); send_digit(4'd0); send_digit(4'd0); send_digit(4'd0);
    do_commit();
    wait_idle("zero", n);
    check_eq("zero busy cycles", 64'(n), 4);
`ifdef FDIV_RANGE_CHECK_EN
    check_eq("zero err", 64'(err), 1);
    check_eq("zero out_valid kept", 64'(out_valid), 1);
    check_eq("zero hp kept", 64'(half_period), 25);
`else
    check_eq("zero err", 64'(err), 0);
    check_eq("zero out_valid", 64'(out_valid), 0);
    check_eq("zero clk_out", 64'(clk_out), 0);
`endif

    // 99.9 MHz
    send_digit(4'd9); send_digit(4'd9); send_digit(4'd9); send_digit(4'd5);
    do_commit();
    wait_idle("high", n);
`ifdef FDIV_RANGE_CHECK_EN
    check_eq("high busy cycles", 64'(n), 9);
    check_eq("high err", 64'(err), 1);
    check_eq("high hp kept", 64'(half_period), 25);
`else
    check_eq("high busy cycles", 64'(n), 42);
    check_eq("high hp", 64'(half_period), 1);
    check_eq("high clk0", 64'(clk_out), 1);
    tick();
    check_eq("high clk1", 64'(clk_out), 0);
    tick();
    check_eq("high clk2", 64'(clk_out), 1);
`endif

    // Entry edge cases
    send_digit(4'hC);
    check_eq("drop ptr", 64'(disp_ptr), 0);
    check_eq("drop disp", 64'(disp_bcd), 64'h5999);
    for (int i = 1; i <= 5; i++) send_digit(4'(i));
    check_eq("wrap disp", 64'(disp_bcd), 64'h4325);
    check_eq("wrap ptr", 64'(disp_ptr), 1);
    send_digit(4'd0); send_digit(4'd1);
    check_eq("pre disp", 64'(disp_bcd), 64'h4105);
    // Exponent digit arrives with commit: 105 kHz -> 238 (without it 1.05 MHz -> 23)
    dv = 1'b1; dg = 4'd3; commit = 1'b1;
    tick();
    dv = 1'b0; dg = 4'd0; commit = 1'b0;
    total = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) total++;
      tick();
    end
    dv = 1'b1; dg = 4'd7; commit = 1'b1;
    if (busy) total++;
    tick();
    dv = 1'b0; dg = 4'd0; commit = 1'b0;
    wait_idle("same", m);
    total += m;
`ifdef FDIV_RANGE_CHECK_EN
    check_eq("busy commit ignored", 64'(total >= 40 && total <= 89), 1);
`else
    check_eq("busy commit ignored", 64'(total >= 40 && total <= 41), 1);
`endif
    check_eq("same-cycle hp", 64'(half_period), 238);
    check_eq("same-cycle disp", 64'(disp_bcd), 64'h3105);
    check_eq("same-cycle ptr", 64'(disp_ptr), 0);
    check_eq("same-cycle err cleared", 64'(err), 0);

    // Reset during DIV
    do_commit();
    repeat (19) tick();
    check_eq("middiv busy", 64'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mrst busy", 64'(busy), 0);
    check_eq("mrst out_valid", 64'(out_valid), 0);
    check_eq("mrst clk_out", 64'(clk_out), 0);
    check_eq("mrst hp", 64'(half_period), 0);
    check_eq("mrst disp", 64'(disp_bcd), 0);
    check_eq("mrst ptr", 64'(disp_ptr), 0);
    check_eq("mrst err", 64'(err), 0);
    check_eq("mrst ready", 64'(digit_ready), 1);
    repeat (100) tick();
    check_eq("mrst no apply hp", 64'(half_period), 0);
    check_eq("mrst no apply valid", 64'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
